mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, word-address width of the data memory port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports enable input 1 (start pulse from execute) and done output 1 (one-cycle completion pulse to writeback).
REQ-005 SHALL have port memop  input  2  00 pass-through, 01 load, 10 store, 11 treated as 00.
REQ-006 SHALL have port funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-007 SHALL have ports addr input 32 (byte address), sdata input 32 (store data), exdata input 32 (pass-through result).
REQ-008 SHALL have ports wselector_in input 2 and rd_in input 5, the writeback selector and destination from execute.
REQ-009 SHALL have outputs wselector 2, data 32 and rd 5, consumed by writeback.
REQ-010 SHALL have memory ports: mem_req out 1, mem_we out 1, mem_addr out ADDR_WIDTH, mem_wdata out 32, mem_wstrb out 4, mem_rdata in 32, mem_ack in 1.
REQ-011 SHALL have port misalign  output  1  misaligned-access flag, valid while done=1.

Function
REQ-012 SHALL implement states IDLE, REQ, FIN; inputs are sampled only in IDLE when enable=1; enable in REQ or FIN is ignored.
REQ-013 SHALL, on accept, latch memop, funct3, addr, sdata, exdata, wselector_in and rd_in; later input changes have no effect.
REQ-014 Pass-through: IDLE->FIN; done=1 in the next cycle with data=exdata, wselector=wselector_in, rd=rd_in.
REQ-015 Load/store: IDLE->REQ; mem_req=1 starting the cycle after accept and held until mem_ack=1 is sampled; mem_we, mem_addr, mem_wdata and mem_wstrb are stable for the whole request.
REQ-016 SHALL drive mem_addr=addr[ADDR_WIDTH+1:2].
REQ-017 On mem_ack in REQ: drop mem_req in the next cycle and go to FIN; done=1 in that next cycle. Latency: accept at t, ack sampled at t+k (k>=1), done at t+k+1.
REQ-018 Load: lane selected by addr[1:0] (B) or addr[1] (H); B/H sign-extended, BU/HU zero-extended, W unmodified; wselector=wselector_in, rd=rd_in.
REQ-019 Store: B replicates sdata[7:0] into all 4 lanes with a one-hot strobe; H replicates sdata[15:0] with strobe 0011 or 1100; W uses strobe 1111; wselector=00 at done.
REQ-020 SHALL ignore mem_ack when mem_req=0.
REQ-021 FIN->IDLE unconditionally after one cycle; done, mem_req and misalign are never high for two consecutive cycles per operation, except mem_req while waiting.
REQ-022 data, wselector and rd SHALL hold their values until the next done.

Reset
REQ-023 rstn=0 SHALL force, immediately and without a clock edge, state=IDLE and done, mem_req, mem_we, misalign=0, mem_wstrb=0, wselector=00, data=0, rd=0, mem_addr=0, mem_wdata=0.
REQ-024 Reset during REQ SHALL abandon the request with no done; the first enable after rstn rises is accepted normally.

Configuration
REQ-025 Macro MEM_MISALIGN_CHECK_EN defined: an H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL skip the memory request; go IDLE->FIN with done=1 next cycle, misalign=1, wselector=00.
REQ-026 Macro MEM_MISALIGN_CHECK_EN undefined: misalign is tied to 0; H uses addr[1] only; W ignores addr[1:0] and accesses the containing word.

Verification
REQ-027 memop=00, exdata=32'h1234_5678, wselector_in=10, rd_in=5 -> done one cycle after enable, data=32'h1234_5678, wselector=10, rd=5, mem_req never high.
REQ-028 Load B, addr=32'h0000_0103, mem_rdata=32'h80FF_0000, ack after 3 cycles -> mem_addr=17'h0040, mem_req high for 3 cycles, done next cycle, data=32'hFFFF_FF80.
REQ-029 Store H, addr=32'h0000_0002, sdata=32'h0000_ABCD, ack same cycle as first req -> mem_we=1, mem_wstrb=1100, mem_wdata=32'hABCD_ABCD, done at t+2, wselector=00.
REQ-030 Load W in progress, rstn pulsed low before ack -> mem_req and done drop immediately; no done is issued; next enable completes normally.
REQ-031 With MEM_MISALIGN_CHECK_EN defined, load W at addr=32'h0000_0001 -> no mem_req; done and misalign=1 next cycle, wselector=00.
REQ-032 enable held high during a 4-cycle load -> exactly one done; the second operation is accepted only when IDLE is reached.

Source files
------------

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- memory-access stage between execute and writeback.
//
// Accepts one operation per enable pulse while idle, then either
// passes the execute result straight through or performs a single load/store
// handshake on the data-memory port. The result goes to writeback together
// with a one-cycle done pulse.
//
// Optional feature (compile-time macro MEM_MISALIGN_CHECK_EN):
//   defined   : misaligned H/HU/W accesses skip the memory request and
//               complete immediately with misalign=1 and wselector=00.
//   undefined : misalign is tied low; H uses addr[1], W uses the containing word.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   enable / done             start pulse from execute / completion pulse
//   memop[1:0]                00 pass, 01 load, 10 store, 11 pass
//   funct3[2:0]               000 B, 001 H, 010 W, 100 BU, 101 HU, other W
//   addr, sdata, exdata       byte address, store data, pass-through result
//   wselector_in, rd_in       writeback selector / destination from execute
//   wselector, data, rd       registered results to writeback (held until next done)
//   mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ack   data-memory port
//   misalign                  misaligned-access flag, valid while done=1
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    output logic                  done,
    input  logic [1:0]            memop,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           sdata,
    input  logic [31:0]           exdata,
    input  logic [1:0]            wselector_in,
    input  logic [4:0]            rd_in,
    output logic [1:0]            wselector,
    output logic [31:0]           data,
    output logic [4:0]            rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t state_reg, state_next;

    // operation context captured on accept
    logic                  store_reg;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;
    logic [1:0]            lane_reg;
    logic [1:0]            wsel_lat_reg;
    logic [4:0]            rd_lat_reg;
    logic                  mis_reg;
    logic [ADDR_WIDTH-1:0] maddr_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            wstrb_reg;

    // writeback-facing results
    logic [31:0]           data_reg;
    logic [1:0]            wsel_reg;
    logic [4:0]            rd_reg;

    // decode of the current inputs (only meaningful on accept)
    logic                  accept;
    logic                  is_mem_in;
    logic                  is_store_in;
    logic [1:0]            size_in;
    logic                  unsigned_in;
    logic [1:0]            lane_in;
    logic                  mis_in;
    logic [31:0]           wdata_in;
    logic [3:0]            wstrb_in;
    logic [31:0]           rshift;
    logic [31:0]           load_val;

    // upper address bits beyond the memory window are intentionally dropped
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign accept      = (state_reg == IDLE) && enable;
    assign is_mem_in   = (memop == 2'b01) || (memop == 2'b10);
    assign is_store_in = (memop == 2'b10);

    always_comb begin
        size_in     = SZ_W;
        unsigned_in = 1'b0;
        case (funct3)
            3'b000:  size_in = SZ_B;
            3'b001:  size_in = SZ_H;
            3'b100:  begin size_in = SZ_B; unsigned_in = 1'b1; end
            3'b101:  begin size_in = SZ_H; unsigned_in = 1'b1; end
            default: size_in = SZ_W;
        endcase
    end

    // Byte lane of the access: halfwords always start on an even lane, so
    // only addr[1] selects; words always use lane 0 of the containing word.
    always_comb begin
        lane_in  = 2'd0;
        wdata_in = sdata;
        wstrb_in = 4'b1111;
        case (size_in)
            SZ_B: begin
                lane_in  = addr[1:0];
                wdata_in = {4{sdata[7:0]}};
                wstrb_in = 4'b0001 << addr[1:0];
            end
            SZ_H: begin
                lane_in  = {addr[1], 1'b0};
                wdata_in = {2{sdata[15:0]}};
                wstrb_in = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_in  = 2'd0;
                wdata_in = sdata;
                wstrb_in = 4'b1111;
            end
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_in = is_mem_in &&
                    (((size_in == SZ_H) && addr[0]) ||
                     ((size_in == SZ_W) && (addr[1:0] != 2'b00)));
`else
    assign mis_in = 1'b0;
`endif

    // load lane extraction and extension
    assign rshift = mem_rdata >> {lane_reg, 3'b000};

    always_comb begin
        load_val = mem_rdata;
        case (size_reg)
            SZ_B:    load_val = unsigned_reg ? {24'd0, rshift[7:0]}
                                             : {{24{rshift[7]}}, rshift[7:0]};
            SZ_H:    load_val = unsigned_reg ? {16'd0, rshift[15:0]}
                                             : {{16{rshift[15]}}, rshift[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = (is_mem_in && !mis_in) ? REQ : FIN;
                end
            end
            REQ:     if (mem_ack) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        done      = (state_reg == FIN);
        misalign  = (state_reg == FIN) && mis_reg;
        mem_req   = (state_reg == REQ);
        mem_we    = (state_reg == REQ) && store_reg;
        mem_wstrb = ((state_reg == REQ) && store_reg) ? wstrb_reg : 4'b0000;
        mem_addr  = maddr_reg;
        mem_wdata = wdata_reg;
        wselector = wsel_reg;
        data      = data_reg;
        rd        = rd_reg;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            store_reg    <= 1'b0;
            size_reg     <= SZ_W;
            unsigned_reg <= 1'b0;
            lane_reg     <= 2'd0;
            wsel_lat_reg <= 2'd0;
            rd_lat_reg   <= 5'd0;
            mis_reg      <= 1'b0;
            maddr_reg    <= '0;
            wdata_reg    <= 32'd0;
            wstrb_reg    <= 4'd0;
            data_reg     <= 32'd0;
            wsel_reg     <= 2'd0;
            rd_reg       <= 5'd0;
        end else if (accept) begin
            store_reg    <= is_store_in;
            size_reg     <= size_in;
            unsigned_reg <= unsigned_in;
            lane_reg     <= lane_in;
            wsel_lat_reg <= wselector_in;
            rd_lat_reg   <= rd_in;
            mis_reg      <= mis_in;
            maddr_reg    <= addr[ADDR_WIDTH+1:2];
            wdata_reg    <= wdata_in;
            wstrb_reg    <= wstrb_in;
            // operations finishing without a memory cycle publish results now,
            // which coincides with the done pulse in the following cycle
            if (!is_mem_in) begin
                data_reg <= exdata;
                wsel_reg <= wselector_in;
                rd_reg   <= rd_in;
            end else if (mis_in) begin
                wsel_reg <= 2'b00;
                rd_reg   <= rd_in;
            end
        end else if ((state_reg == REQ) && mem_ack) begin
            rd_reg <= rd_lat_reg;
            if (store_reg) begin
                wsel_reg <= 2'b00;
            end else begin
                data_reg <= load_val;
                wsel_reg <= wsel_lat_reg;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        done;
    logic [1:0]  memop;
    logic [2:0]  funct3;
    logic [31:0] addr, sdata, exdata;
    logic [1:0]  wselector_in, wselector;
    logic [4:0]  rd_in, rd;
    logic [31:0] data;
    logic        mem_req, mem_we, mem_ack, misalign;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_access #(.ADDR_WIDTH(17)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .done(done),
        .memop(memop), .funct3(funct3), .addr(addr), .sdata(sdata),
        .exdata(exdata), .wselector_in(wselector_in), .rd_in(rd_in),
        .wselector(wselector), .data(data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  wsel;
        logic [4:0]  rd;
        logic        mis;
        int          cyc;
        bit          chk_data;
    } res_t;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          k;
    } mreq_t;

    res_t  res_q[$];
    mreq_t mem_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: derives the expected memory transaction and the
    // writeback result directly from the access rules.
    task automatic predict(input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] ex, input logic [1:0] ws,
                           input logic [4:0] r, input int k,
                           input logic [31:0] rdv, input int acc);
        res_t  e;
        mreq_t m;
        int    size;
        int    off;
        bit    sgn;
        bit    mis;
        logic [63:0] raw, mask, val;
        e.data = 32'd0; e.wsel = ws; e.rd = r; e.mis = 1'b0; e.cyc = acc; e.chk_data = 1'b1;
        if (op == 2'b01 || op == 2'b10) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd4: begin size = 1; sgn = 1'b0; end
                3'd5: begin size = 2; sgn = 1'b0; end
                default: begin size = 4; sgn = 1'b0; end
            endcase
            mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            mis = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
`endif
            if (mis) begin
                e.wsel = 2'b00; e.mis = 1'b1; e.chk_data = 1'b0;
            end else begin
                off = (size == 1) ? int'(a[1:0]) : (size == 2) ? 2 * int'(a[1]) : 0;
                m.addr  = a[18:2];
                m.we    = (op == 2'b10);
                m.rdata = rdv;
                m.k     = k;
                m.wstrb = 4'b0000;
                m.wdata = 32'd0;
                for (int j = 0; j < 4; j++) m.wdata[8*j +: 8] = sd[8*(j % size) +: 8];
                for (int j = 0; j < size; j++) m.wstrb[off + j] = 1'b1;
                mem_q.push_back(m);
                e.cyc = acc + k;
                if (op == 2'b10) begin
                    e.wsel = 2'b00; e.chk_data = 1'b0;
                end else begin
                    raw  = {32'd0, rdv} >> (8 * off);
                    mask = (64'd1 << (8 * size)) - 64'd1;
                    val  = raw & mask;
                    if (sgn && size < 4 && val[8*size-1]) val = val | ~mask;
                    e.data = val[31:0];
                end
            end
        end else begin
            e.data = ex;
        end
        res_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        res_t e;
        if (rstn) begin
            if (done) begin
                done_cnt++;
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = res_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wselector", 32'(wselector), 32'(e.wsel));
                    chk("rd", 32'(rd), 32'(e.rd));
                    chk("misalign", 32'(misalign), 32'(e.mis));
                    if (e.chk_data) chk("data", data, e.data);
                    $display("done cyc=%0d data=%h wsel=%0d rd=%0d mis=%0b", cyc, data, wselector, rd, misalign);
                end
            end else if (misalign) begin
                chk("misalign_without_done", 32'd1, 32'd0);
            end
        end
    end

    // ---------------- memory responder ----------------
    int req_cnt = 0;
    always @(negedge clk) begin
        mreq_t m;
        if (!rstn) begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (mem_q.size() == 0) begin
                chk("spurious_mem_req", 32'd1, 32'd0);
                mem_ack = 1'b0;
            end else begin
                m = mem_q[0];
                req_cnt++;
                chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                chk("mem_we", 32'(mem_we), 32'(m.we));
                if (m.we) begin
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
                    chk("mem_wdata", mem_wdata, m.wdata);
                end
                if (req_cnt == m.k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = m.rdata;
                    void'(mem_q.pop_front());
                    req_cnt = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end else begin
            // stray acks while no request is pending must be ignored
            req_cnt   = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // ---------------- driver ----------------
    task automatic set_inputs(input logic [1:0] op, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] ex, input logic [1:0] ws,
                              input logic [4:0] r);
        memop = op; funct3 = f3; addr = a; sdata = sd; exdata = ex;
        wselector_in = ws; rd_in = r;
    endtask

    task automatic scramble_inputs();
        set_inputs(2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   2'($urandom), 5'($urandom));
    endtask

    task automatic wait_done(input int target);
        int n;
        for (n = 0; n < 60; n++) begin
            if (done_cnt >= target) break;
            @(posedge clk); #1;
        end
        if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    // Call with the DUT idle, at posedge+1.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] ex, input logic [1:0] ws,
                          input logic [4:0] r, input int k, input logic [31:0] rdv);
        int s;
        int acc;
        s = done_cnt;
        set_inputs(op, f3, a, sd, ex, ws, r);
        enable = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        predict(op, f3, a, sd, ex, ws, r, k, rdv, acc);
        $display("issue cyc=%0d op=%0d f3=%0d addr=%h sdata=%h ex=%h k=%0d", acc, op, f3, a, sd, ex, k);
        enable = 1'b0;
        scramble_inputs();
        wait_done(s + 1);
    endtask

    initial begin
        int s, a1, a2;
        enable = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        set_inputs(2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 2'd0, 5'd0);
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_rd_wsel", {25'd0, rd, wselector}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // pass-through
        run_op(2'b00, 3'd0, 32'h0, 32'h0, 32'h1234_5678, 2'b10, 5'd5, 0, 32'h0);
        chk("pass_data", data, 32'h1234_5678);
        // byte load, sign-extended from lane 3
        run_op(2'b01, 3'd0, 32'h0000_0103, 32'h0, 32'h0, 2'b01, 5'd7, 3, 32'h80FF_0000);
        chk("lb_data", data, 32'hFFFF_FF80);
        // halfword store to upper half, ack on first request cycle
        run_op(2'b10, 3'd1, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 2'b11, 5'd9, 1, 32'h0);
        chk("sh_wsel", 32'(wselector), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        run_op(2'b01, 3'd2, 32'h0000_0001, 32'h0, 32'h0, 2'b01, 5'd3, 0, 32'h0);
`endif

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   2'($urandom), 5'($urandom), $urandom_range(1, 4), $urandom);
        end

        // enable held high across a 4-cycle load: second op waits for IDLE
        s = done_cnt;
        set_inputs(2'b01, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 2'b01, 5'd11);
        enable = 1'b1;
        @(posedge clk); #1;
        a1 = cyc;
        predict(2'b01, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 2'b01, 5'd11, 4, 32'hCAFE_F00D, a1);
        set_inputs(2'b00, 3'd0, 32'h0, 32'h0, 32'h5555_AAAA, 2'b11, 5'd12);
        a2 = a1 + 4 + 2;
        predict(2'b00, 3'd0, 32'h0, 32'h0, 32'h5555_AAAA, 2'b11, 5'd12, 0, 32'h0, a2);
        for (int n = 0; n < 30 && cyc < a2; n++) begin
            @(posedge clk); #1;
        end
        enable = 1'b0;
        wait_done(s + 2);

        // reset in the middle of a load request
        set_inputs(2'b01, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 2'b01, 5'd4);
        enable = 1'b1;
        @(posedge clk); #1;
        predict(2'b01, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 2'b01, 5'd4, 8, 32'h0, cyc);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_data", data, 32'd0);
        res_q.delete();
        mem_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 3'd5, 32'h0000_0006, 32'h0, 32'h0, 2'b10, 5'd21, 2, 32'h9876_5432);

        repeat (5) @(posedge clk);
        #1;
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
